axis_rr_arbiter: RTL
====================

// Module: axis_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one AXI-stream-style sink (e.g. axis_fifo
//  input) between COUNT valid/ready sources (e.g. several axis_counter).
//  Grants one source at a time for a burst of up to BURST beats, then rotates.
//  Output is registered (one beat buffer); decouples sink ready from sources.
// PARAMETERS
//  WIDTH  8  data bits per beat
//  COUNT  4  number of requesters, 2..16
//  BURST  4  max beats per grant, 1..256
// PORTS
//  clock   in   1             single clock, all logic on rising edge
//  resetn  in   1             synchronous active-low reset
//  idata   in   COUNT*WIDTH   source i data at [i*WIDTH +: WIDTH]
//  ivalid  in   COUNT         source i has a beat
//  iready  out  COUNT         source i beat accepted this cycle
//  odata   out  WIDTH         registered output data
//  ovalid  out  1             registered output valid
//  oready  in   1             sink accepts odata
//  grant   out  $clog2(COUNT) index of current/last granted source
//  busy    out  1             1 while in GRANT state
// BEHAVIOUR
//  Reset (resetn=0 at edge): state=IDLE, ovalid=0, odata=0, grant=COUNT-1,
//   beat counter=0, iready=0. Reset mid-burst drops the output beat at once.
//  Transfer: beat moves when valid&&ready at same edge, both sides.
//  iready[i] = busy && grant==i && (!ovalid || oready); combinational, all
//   other bits 0. At most one iready bit set, ever.
//  Output stage: on input transfer, odata<=idata[grant], ovalid<=1; else if
//   oready, ovalid<=0. odata holds while ovalid && !oready. Latency 1 clock.
//   Simultaneous sink pop and source push: ovalid stays 1, new data loaded.
//  FSM:
//   IDLE: search ivalid from (grant+1) mod COUNT upward, wrapping; first set
//    bit wins -> grant<=idx, count<=0, GRANT. None set -> stay IDLE.
//    Arbitration costs one idle cycle (no transfer in IDLE).
//   GRANT: on transfer count<=count+1; if count==BURST-1 at transfer -> IDLE.
//    If ivalid[grant]==0 in a cycle -> IDLE next edge (no transfer that cycle).
//    Both conditions release; grant keeps value for next rotation.
//  Fairness: source just served has lowest priority next search; with all
//   sources valid, grants go g+1,g+2,.. mod COUNT, BURST beats each.
//  count width $clog2(BURST)+1; no wrap since released at BURST-1.
//  BURST=1: one beat per grant, then IDLE; peak rate 1 beat / 2 clocks.
//  Backpressure: oready=0 with ovalid=1 stalls iready; grant/count held.
//  busy = (state==GRANT).
// TESTING
//  Reset: resetn=0 2 clocks, ivalid=4'b1111 -> iready=0, ovalid=0, grant=3.
//  Single source: ivalid=4'b0100, data 0,1,2..; oready=1 -> grant=2, 4 beats
//   0..3 on odata, 1 idle, next 4 beats 4..7; no data lost or duplicated.
//  All valid, oready=1, BURST=4 -> grants 0,1,2,3,0 in order, 4 beats each,
//   per-source order preserved, one idle cycle between bursts.
//  Backpressure: oready=0 for 5 clocks mid-burst -> odata/ovalid frozen,
//   iready=0, count unchanged; on oready=1 burst resumes at next beat.
//  Source drop: src1 valid for 2 beats then ivalid[1]=0 -> IDLE, grant moves
//   to next valid source (2), src1 beats not repeated.
//  Reset mid-burst: resetn=0 while ovalid=1 -> next edge ovalid=0, IDLE,
//   first post-reset grant goes to lowest-index valid source (0).

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter, its COUNT sources and its one sink.
// The master modport is the arbiter's own view; the slave modport is the view of
// whatever drives the sources and consumes the sink side.
interface axis_rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
);
  localparam int GW = $clog2(COUNT);

  logic [COUNT*WIDTH-1:0] idata;
  logic [COUNT-1:0]       ivalid;
  logic [COUNT-1:0]       iready;
  logic [WIDTH-1:0]       odata;
  logic                   ovalid;
  logic                   oready;
  logic [GW-1:0]          grant;
  logic                   busy;

  modport master (
    input  idata, ivalid, oready,
    output iready, odata, ovalid, grant, busy
  );

  modport slave (
    output idata, ivalid, oready,
    input  iready, odata, ovalid, grant, busy
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink between COUNT sources.
// A source keeps the grant for up to BURST beats, or until it drops valid.
// After that, one idle cycle is spent re-arbitrating. The search starts just
// after the last winner, so the source served most recently ranks lowest.
// A one-beat output register isolates the sink's ready from the sources.
module axis_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int BURST = 4
) (
  input logic               clock,
  input logic               resetn,
  axis_rr_arbiter_if.master bus
);
  localparam int GW = $clog2(COUNT);
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_grant;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_odata;
  logic             r_ovalid;

  logic             w_busy;
  logic             w_canAccept;
  logic             w_selValid;
  logic             w_xfer;
  logic [WIDTH-1:0] w_selData;
  logic [COUNT-1:0] w_iready;
  logic             w_found;
  logic [GW-1:0]    w_nextGrant;
  int               w_bestDist;

  assign w_busy      = (r_state == GRANT);
  assign w_canAccept = !r_ovalid || bus.oready;
  assign w_selValid  = bus.ivalid[r_grant];
  assign w_xfer      = w_busy && w_selValid && w_canAccept;

  // Steer the granted source's data forward and raise only its ready bit
  always_comb begin
    w_selData = '0;
    w_iready  = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (r_grant == GW'(i)) begin
        w_selData   = bus.idata[i*WIDTH +: WIDTH];
        w_iready[i] = w_busy && w_canAccept;
      end
    end
  end

  // Pick the valid source nearest after the last winner, wrapping around
  always_comb begin
    w_found     = 1'b0;
    w_nextGrant = r_grant;
    w_bestDist  = COUNT;
    for (int i = 0; i < COUNT; i++) begin
      if (bus.ivalid[i] && (((i - int'(r_grant) - 1 + 2*COUNT) % COUNT) < w_bestDist)) begin
        w_bestDist  = (i - int'(r_grant) - 1 + 2*COUNT) % COUNT;
        w_nextGrant = GW'(i);
        w_found     = 1'b1;
      end
    end
  end

  // Grant FSM: arbitrate in IDLE, then count beats in GRANT until release
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= GW'(COUNT - 1);
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_nextGrant;
            r_count <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!w_selValid) begin
            r_state <= IDLE;
          end else if (w_xfer) begin
            r_count <= r_count + 1'b1;
            if (r_count == CW'(BURST - 1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output buffer: load on every accepted beat, drain when the sink takes it
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_odata  <= '0;
      r_ovalid <= 1'b0;
    end else if (w_xfer) begin
      r_odata  <= w_selData;
      r_ovalid <= 1'b1;
    end else if (bus.oready) begin
      r_ovalid <= 1'b0;
    end
  end

  assign bus.iready = w_iready;
  assign bus.odata  = r_odata;
  assign bus.ovalid = r_ovalid;
  assign bus.grant  = r_grant;
  assign bus.busy   = w_busy;
endmodule
